// File: rtl/branch_resolve_pkg.sv
// Shared types and constants for branch resolution.
// Counter helper used by the direction table.
package branch_resolve_pkg;

  typedef logic [63:0] u64;
  typedef logic [2:0]  u3;
  typedef logic [1:0]  u2;
  typedef logic        u1;

  typedef u2 bht_cnt_t;

  localparam bht_cnt_t BHT_WEAK_NT = 2'b01;

  localparam u3 F3_BEQ  = 3'b000;
  localparam u3 F3_BNE  = 3'b001;
  localparam u3 F3_BLT  = 3'b100;
  localparam u3 F3_BGE  = 3'b101;
  localparam u3 F3_BLTU = 3'b110;
  localparam u3 F3_BGEU = 3'b111;

  typedef struct packed {
    u1  valid;
    u64 pc;
  } redirect_t;

  function automatic bht_cnt_t satNext(
    input bht_cnt_t c,
    input u1        tk
  );
    bht_cnt_t n;
    n = c;
    if (tk && c != 2'b11)
      n = c + 2'b01;
    else if (!tk && c != 2'b00)
      n = c - 2'b01;
    return n;
  endfunction

endpackage

// File: rtl/branch_resolve_if.sv
// Execute-side instruction bundle plus the redirect channel to fetch.
// master drives instructions and redirect_ready; slave is the resolver.
interface branch_resolve_if;
  import branch_resolve_pkg::*;

  u1  in_valid;
  u1  in_ready;
  u64 pc;
  u64 imm;
  u64 rs1_val;
  u1  is_branch;
  u1  is_jal;
  u1  is_jalr;
  u3  funct3;
  u1  pred_taken;
  u64 pred_target;
  u1  redirect_valid;
  u64 redirect_pc;
  u1  redirect_ready;

  modport master (
    output in_valid, pc, imm, rs1_val,
    output is_branch, is_jal, is_jalr,
    output funct3, pred_taken, pred_target,
    output redirect_ready,
    input  in_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  in_valid, pc, imm, rs1_val,
    input  is_branch, is_jal, is_jalr,
    input  funct3, pred_taken, pred_target,
    input  redirect_ready,
    output in_ready, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/branch_resolve_bht_table.sv
// Bimodal 2-bit direction table: one comb read port,
// one synchronous saturating update port, async reset.
module bht_table
  import branch_resolve_pkg::*;
#(
  parameter int       IDX_W     = 6,
  parameter bht_cnt_t RESET_CNT = BHT_WEAK_NT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rdIdx,
  output logic             rdTaken,
  input  logic             wrEn,
  input  logic [IDX_W-1:0] wrIdx,
  input  logic             wrTaken
);

  localparam int N = 1 << IDX_W;

  bht_cnt_t cnt [N];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++)
        cnt[i] <= RESET_CNT;
    end else if (wrEn) begin
      cnt[wrIdx] <= satNext(cnt[wrIdx], wrTaken);
    end
  end

  // Reads the stored value, so a same-cycle update shows next cycle.
  assign rdTaken = cnt[rdIdx][1];

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch/JAL/JALR resolver with registered redirect.
// Define BRANCH_STATS_EN to add stat_branches/stat_mispred counters.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int       BHT_IDX_W = 6,
  parameter bht_cnt_t RESET_CNT = BHT_WEAK_NT
) (
  input  logic              clk,
  input  logic              reset,
  branch_resolve_if.slave   ex,
  output logic              BrUn,
  input  logic              BrEq,
  input  logic              BrLT,
  input  u64                lookup_pc,
  output logic              lookup_taken
`ifdef BRANCH_STATS_EN
  ,
  output u64                stat_branches,
  output u64                stat_mispred
`endif
);

  redirect_t rdr;

  logic condTaken;
  logic f3Ok;
  logic taken;
  logic mispredict;
  logic accept;
  logic live;
  logic launch;
  logic bhtWr;
  logic isCtrl;
  u64   jalrSum;
  u64   target;
  u64   nextPc;

  assign BrUn = ex.funct3[1];

  always_comb begin
    condTaken = 1'b0;
    f3Ok      = 1'b1;
    unique case (1'b1)
      (ex.funct3 == F3_BEQ):
        condTaken = BrEq;
      (ex.funct3 == F3_BNE):
        condTaken = !BrEq;
      (ex.funct3 == F3_BLT),
      (ex.funct3 == F3_BLTU):
        condTaken = BrLT;
      (ex.funct3 == F3_BGE),
      (ex.funct3 == F3_BGEU):
        condTaken = !BrLT;
      default:
        f3Ok = 1'b0;
    endcase
  end

  assign taken = ex.is_jal || ex.is_jalr
              || (ex.is_branch && f3Ok && condTaken);

  assign jalrSum = ex.rs1_val + ex.imm;

  assign target = ex.is_jalr
                ? {jalrSum[63:1], 1'b0}
                : ex.pc + ex.imm;

  assign nextPc = taken ? target : ex.pc + 64'd4;

  // Reserved funct3 encodings resolve not-taken and never redirect.
  assign mispredict =
      !(ex.is_branch && !f3Ok)
   && ((taken != ex.pred_taken)
    || (taken && ex.pred_target != target));

  assign ex.in_ready = !rdr.valid || ex.redirect_ready;
  assign accept      = ex.in_valid && ex.in_ready;
  assign live        = accept && !rdr.valid;
  assign launch      = live && mispredict;
  assign bhtWr       = live && ex.is_branch && f3Ok;
  assign isCtrl      = ex.is_branch || ex.is_jal || ex.is_jalr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdr <= '0;
    end else if (rdr.valid && ex.redirect_ready) begin
      rdr.valid <= 1'b0;
    end else if (launch) begin
      rdr.valid <= 1'b1;
      rdr.pc    <= nextPc;
    end
  end

  assign ex.redirect_valid = rdr.valid;
  assign ex.redirect_pc    = rdr.pc;

  bht_table #(
    .IDX_W     (BHT_IDX_W),
    .RESET_CNT (RESET_CNT)
  ) u_bht (
    .clk     (clk),
    .reset   (reset),
    .rdIdx   (lookup_pc[BHT_IDX_W+1:2]),
    .rdTaken (lookup_taken),
    .wrEn    (bhtWr),
    .wrIdx   (ex.pc[BHT_IDX_W+1:2]),
    .wrTaken (taken)
  );

  logic unusedBits;
  assign unusedBits = ^{lookup_pc[63:BHT_IDX_W+2],
                        lookup_pc[1:0]};

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else begin
      if (live && isCtrl)
        stat_branches <= stat_branches + 64'd1;
      if (launch)
        stat_mispred <= stat_mispred + 64'd1;
    end
  end
`else
  logic unusedCtrl;
  assign unusedCtrl = isCtrl;
`endif

endmodule
